// File: rtl/timer_ctrl.sv
// Run/setup controller for the MM:SS countdown timer: button pulses to preset digits,
// a one-cycle load strobe, a gated count enable, and alarm/fault handling.
module timer_ctrl #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       done,
    input  logic       error,
    output logic       load,
    output logic       CE,
    output logic [3:0] I1,
    output logic [3:0] I0,
    output logic [1:0] edit_digit,
    output logic [2:0] state,
    output logic       alarm
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDIT_T = 3'd1,
        S_EDIT_O = 3'd2,
        S_LOAD   = 3'd3,
        S_RUN    = 3'd4,
        S_PAUSE  = 3'd5,
        S_DONE   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_SEC - 1);

    state_e        state_q, state_d;
    logic [3:0]    i1_q, i1_d, i0_q, i0_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          load_q, load_d, ce_q, ce_d, alarm_q, alarm_d;
    logic [1:0]    edit_digit_q, edit_digit_d;
    logic          preset_nz, counting, tick;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        preset_nz    = ({i1_q, i0_q} != 8'd0);
        counting     = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DONE);
        tick         = counting && (presc_q == PRESC_MAX);
        state_d      = state_q;
        i1_d         = i1_q;
        i0_d         = i0_q;
        alarm_cnt_d  = alarm_cnt_q;
        presc_d      = presc_q;
        if (counting) presc_d = tick ? '0 : presc_q + 1'b1;

        if (error && (state_q inside {S_LOAD, S_RUN, S_PAUSE})) begin
            state_d = S_FAULT;
        end else if (done && (state_q == S_RUN)) begin
            state_d = S_DONE;
        end else begin
            // A start pulse is consumed even when ignored, so it always masks set/up.
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        if (preset_nz) state_d = S_LOAD;
                    end else if (btn_set) state_d = S_EDIT_T;
                end
                S_EDIT_T: begin
                    if (btn_start) begin
                        if (preset_nz) state_d = S_LOAD;
                    end else if (btn_set) state_d = S_EDIT_O;
                    else if (btn_up) i1_d = (i1_q == 4'd9) ? 4'd0 : i1_q + 4'd1;
                end
                S_EDIT_O: begin
                    if (btn_start) begin
                        if (preset_nz) state_d = S_LOAD;
                    end else if (btn_set) state_d = S_IDLE;
                    else if (btn_up) i0_d = (i0_q == 4'd9) ? 4'd0 : i0_q + 4'd1;
                end
                S_LOAD:  state_d = S_RUN;
                S_RUN:   if (btn_start) state_d = S_PAUSE;
                S_PAUSE: begin
                    if (btn_start) state_d = S_RUN;
                    else if (btn_set) state_d = S_IDLE;
                end
                S_DONE: begin
                    if (btn_start || btn_set) begin
                        state_d = S_IDLE;
                    end else if (tick) begin
                        if (alarm_cnt_q == ALARM_MAX) state_d = S_IDLE;
                        else alarm_cnt_d = alarm_cnt_q + 1'b1;
                    end
                end
                S_FAULT: if (btn_set && !error) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Prescaler restarts on LOAD so the first CE lands TICK_DIV cycles after load,
        // and on DONE entry so the alarm lasts exactly ALARM_SEC ticks.
        if (state_d == S_LOAD) presc_d = '0;
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            presc_d     = '0;
            alarm_cnt_d = '0;
        end

        load_d  = (state_d == S_LOAD);
        alarm_d = (state_d == S_DONE);
        ce_d    = (state_q == S_RUN) && (state_d == S_RUN) && tick;
        case (state_d)
            S_EDIT_T: edit_digit_d = 2'b01;
            S_EDIT_O: edit_digit_d = 2'b10;
            default:  edit_digit_d = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            i1_q         <= '0;
            i0_q         <= '0;
            presc_q      <= '0;
            alarm_cnt_q  <= '0;
            load_q       <= 1'b0;
            ce_q         <= 1'b0;
            alarm_q      <= 1'b0;
            edit_digit_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            i1_q         <= i1_d;
            i0_q         <= i0_d;
            presc_q      <= presc_d;
            alarm_cnt_q  <= alarm_cnt_d;
            load_q       <= load_d;
            ce_q         <= ce_d;
            alarm_q      <= alarm_d;
            edit_digit_q <= edit_digit_d;
        end
    end

    assign state      = state_q;
    assign I1         = i1_q;
    assign I0         = i0_q;
    assign load       = load_q;
    assign CE         = ce_q;
    assign alarm      = alarm_q;
    assign edit_digit = edit_digit_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus random button/flag traffic,
// compared every cycle against a cycle-count based behavioural model.
module tb_timer_ctrl;

    localparam int TICK  = 4;
    localparam int ASEC  = 5;
    localparam int IDLE = 0, EDIT_T = 1, EDIT_O = 2, LOAD = 3;
    localparam int RUN = 4, PAUSE = 5, DONE = 6, FAULT = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0, btn_set = 1'b0, btn_up = 1'b0;
    logic       done = 1'b0, error = 1'b0;
    logic       load, ce, alarm;
    logic [3:0] i1, i0;
    logic [1:0] edit_digit;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: state, preset digits, cycles counted since load, cycles spent in DONE.
    int m_state, m_prev, m_i1, m_i0, m_elapsed, m_done_cyc;

    timer_ctrl #(.TICK_DIV(TICK), .ALARM_SEC(ASEC)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_set(btn_set),
        .btn_up(btn_up), .done(done), .error(error), .load(load), .CE(ce),
        .I1(i1), .I0(i0), .edit_digit(edit_digit), .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_prev = IDLE; m_i1 = 0; m_i0 = 0; m_elapsed = 0; m_done_cyc = 0;
    endtask

    task automatic model_step(input bit s, input bit st, input bit u, input bit d, input bit e);
        int  nxt;
        bit  nz;
        nxt = m_state;
        nz  = (m_i1 != 0) || (m_i0 != 0);
        if (e && (m_state == LOAD || m_state == RUN || m_state == PAUSE)) nxt = FAULT;
        else if (d && m_state == RUN) nxt = DONE;
        else begin
            case (m_state)
                IDLE:   if (s) begin if (nz) nxt = LOAD; end else if (st) nxt = EDIT_T;
                EDIT_T: if (s) begin if (nz) nxt = LOAD; end else if (st) nxt = EDIT_O;
                        else if (u) m_i1 = (m_i1 + 1) % 10;
                EDIT_O: if (s) begin if (nz) nxt = LOAD; end else if (st) nxt = IDLE;
                        else if (u) m_i0 = (m_i0 + 1) % 10;
                LOAD:   nxt = RUN;
                RUN:    if (s) nxt = PAUSE;
                PAUSE:  if (s) nxt = RUN; else if (st) nxt = IDLE;
                DONE:   if (s || st || m_done_cyc == ASEC * TICK - 1) nxt = IDLE;
                FAULT:  if (st && !e) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
        if (m_state == LOAD || m_state == RUN) m_elapsed++;
        if (nxt == LOAD) m_elapsed = 0;
        if (m_state == DONE) m_done_cyc++;
        if (nxt == DONE && m_state != DONE) m_done_cyc = 0;
        m_prev  = m_state;
        m_state = nxt;
    endtask

    task automatic check_all();
        bit exp_ce;
        int exp_ed;
        exp_ce = (m_state == RUN) && (m_prev == RUN) && (m_elapsed % TICK == 0);
        exp_ed = (m_state == EDIT_T) ? 1 : (m_state == EDIT_O) ? 2 : 0;
        chk("state", 8'(state), 8'(m_state));
        chk("load", 8'(load), 8'(m_state == LOAD));
        chk("ce", 8'(ce), 8'(exp_ce));
        chk("alarm", 8'(alarm), 8'(m_state == DONE));
        chk("i1", 8'(i1), 8'(m_i1));
        chk("i0", 8'(i0), 8'(m_i0));
        chk("edit_digit", 8'(edit_digit), 8'(exp_ed));
    endtask

    // One clock: buttons are pulses for this edge only; done/error keep their levels.
    task automatic cyc(input bit s, input bit st, input bit u);
        btn_start = s; btn_set = st; btn_up = u;
        @(posedge clk);
        model_step(s, st, u, done, error);
        #1;
        btn_start = 1'b0; btn_set = 1'b0; btn_up = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        int ce_cnt, alarm_cnt, r;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_all();

        // Edit 37 and start: edit_digit 01 -> 10 -> 00, one load, then RUN
        cyc(0, 1, 0);
        chk("t1_edit_t", 8'(edit_digit), 8'd1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        chk("t1_edit_o", 8'(edit_digit), 8'd2);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk("t1_load", 8'(load), 8'd1);
        chk("t1_edit_none", 8'(edit_digit), 8'd0);
        idle(1);
        chk("t1_run", 8'(state), 8'(RUN));
        chk("t1_i1", 8'(i1), 8'd3);
        chk("t1_i0", 8'(i0), 8'd7);

        // Preset 00 start ignored; tens digit wraps after ten ups
        apply_reset();
        cyc(1, 0, 0);
        chk("t2_zero_start", 8'(state), 8'(IDLE));
        cyc(0, 1, 0);
        for (int k = 0; k < 9; k++) cyc(0, 0, 1);
        chk("t2_i1_nine", 8'(i1), 8'd9);
        cyc(0, 0, 1);
        chk("t2_i1_wrap", 8'(i1), 8'd0);
        cyc(0, 1, 0);
        cyc(1, 0, 1);
        chk("t2_start_up_i0", 8'(i0), 8'd0);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("t2_start_wins", 8'(i0), 8'd1);
        chk("t2_load", 8'(load), 8'd1);

        // CE every TICK cycles after load; pause stops it, resume keeps phase
        ce_cnt = 0;
        for (int k = 0; k < 3 * TICK; k++) begin
            cyc(0, 0, 0);
            if (ce) ce_cnt++;
        end
        chk("t3_ce_count", 8'(ce_cnt), 8'd3);
        idle(2);
        cyc(1, 0, 0);
        idle(6);
        chk("t3_paused_ce", 8'(ce), 8'd0);
        cyc(1, 0, 0);
        idle(9);

        // done -> alarm for ASEC*TICK cycles, then IDLE; start acknowledges early
        done = 1'b1;
        cyc(0, 0, 0);
        done = 1'b0;
        alarm_cnt = 1;
        for (int k = 0; k < ASEC * TICK + 3; k++) begin
            cyc(0, 0, 0);
            if (alarm) alarm_cnt++;
        end
        chk("t4_alarm_len", 8'(alarm_cnt), 8'(ASEC * TICK));
        chk("t4_idle", 8'(state), 8'(IDLE));
        chk("t4_preset_kept", {i1, i0}, 8'h01);
        cyc(1, 0, 0);
        idle(3);
        done = 1'b1;
        cyc(0, 0, 0);
        done = 1'b0;
        idle(2);
        cyc(1, 0, 0);
        chk("t4_ack", 8'(state), 8'(IDLE));

        // error with start in PAUSE -> FAULT; set only exits once error clears
        cyc(1, 0, 0);
        idle(3);
        cyc(1, 0, 0);
        error = 1'b1;
        cyc(1, 0, 0);
        chk("t5_fault", 8'(state), 8'(FAULT));
        cyc(0, 1, 0);
        chk("t5_fault_hold", 8'(state), 8'(FAULT));
        error = 1'b0;
        idle(1);
        cyc(0, 1, 0);
        chk("t5_exit", 8'(state), 8'(IDLE));

        // Asynchronous reset mid-RUN, on a CE cycle
        cyc(1, 0, 0);
        idle(TICK);
        chk("t6_ce_before", 8'(ce), 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_ce", 8'(ce), 8'd0);
        chk("t6_async_state", 8'(state), 8'd0);
        chk("t6_async_preset", {i1, i0}, 8'd0);
        apply_reset();

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) done = ~done;
            if ($urandom_range(0, 119) == 0) error = ~error;
            r = $urandom_range(0, 99);
            cyc(r < 8, (r >= 8) && (r < 16), (r >= 16) && (r < 34));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Run/setup controller for the MM:SS countdown timer. Turns three single-cycle button pulses into a preset minutes value (I1:I0), a one-cycle load strobe and a gated 1 Hz count enable (CE) for the timer datapath. It also reacts to the datapath's terminal-count (done) and error flags. It sits between the debounced button logic and the timer, and additionally drives display-mode and alarm outputs.

Parameters:
TICK_DIV, 100000000, clk cycles per count-enable pulse (1 s at 100 MHz); the bench uses 4
ALARM_SEC, 5, number of CE-rate ticks the alarm output stays high in DONE

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_start  input  1  one-cycle pulse: start / pause / resume / acknowledge
btn_set  input  1  one-cycle pulse: enter edit / next digit / abort
btn_up  input  1  one-cycle pulse: increment the digit being edited
done  input  1  timer reached 00:00 (level)
error  input  1  timer error flag (level)
load  output  1  one-cycle strobe; timer captures I1:I0
CE  output  1  one-cycle count enable, every TICK_DIV cycles, only in RUN
I1  output  4  preset minutes tens digit, 0-9
I0  output  4  preset minutes ones digit, 0-9
edit_digit  output  2  00 = none, 01 = tens blinking, 10 = ones blinking
state  output  3  encoded FSM state, for display mode selection
alarm  output  1  high during DONE until timeout or acknowledge

Behaviour:
- Reset (asynchronous): state = IDLE; I1 = I0 = 0; prescaler = 0; alarm counter = 0; all outputs 0.
- State encoding: IDLE = 0, EDIT_T = 1, EDIT_O = 2, LOAD = 3, RUN = 4, PAUSE = 5, DONE = 6, FAULT = 7. All outputs are registered.
- Definition: "preset nonzero" means {I1, I0} != 0.
- Per-cycle priority:
  - error = 1 in LOAD, RUN or PAUSE: go to FAULT.
  - Otherwise done = 1 in RUN: go to DONE.
  - Otherwise button handling, in priority order start > set > up.
- IDLE:
  - start with preset nonzero: go to LOAD. start with preset zero: ignored.
  - set: go to EDIT_T.
- EDIT_T:
  - up: I1 = (I1 == 9) ? 0 : I1 + 1.
  - set: go to EDIT_O.
  - start with preset nonzero: go to LOAD.
- EDIT_O:
  - up: I0 = (I0 == 9) ? 0 : I0 + 1.
  - set: go to IDLE.
  - start with preset nonzero: go to LOAD.
- edit_digit = 01 in EDIT_T, 10 in EDIT_O, 00 in all other states.
- LOAD:
  - load = 1 for exactly this one cycle; next state RUN.
  - Prescaler is cleared in this cycle.
- RUN:
  - Prescaler counts 0 to TICK_DIV-1 and wraps.
  - CE = 1 on the cycle after the prescaler holds TICK_DIV-1. The first CE therefore occurs TICK_DIV cycles after the load cycle.
  - start: go to PAUSE.
- PAUSE:
  - CE = 0; prescaler holds its value.
  - start: go back to RUN, resuming from the held prescaler value.
  - set: go to IDLE (abort).
- DONE:
  - alarm = 1; CE = 0.
  - An internal tick still counts on the prescaler.
  - After ALARM_SEC ticks, or on any start or set pulse: go to IDLE, alarm = 0.
- FAULT:
  - CE = 0; alarm = 0.
  - Only set leaves FAULT, to IDLE, and only when error = 0. Otherwise the state holds.
- Preset I1/I0 is retained through every state (pressing start in IDLE re-runs the same preset). Only reset or an edit changes it.
- up outside EDIT_T/EDIT_O is ignored. Simultaneous start and up in an edit state: start wins and the digit is unchanged.
- load and CE are never high in the same cycle.
- Reset asserted during RUN: CE and load drop immediately.

Test Plan:
1. Reset, then set, up×3, set, up×7, start -> I1 = 3, I0 = 7, edit_digit sequence 01 → 10 → 00, one load pulse, state = RUN.
2. In EDIT_T, apply up×10 -> I1 wraps 9 → 0. In IDLE with preset 00, pulse start -> no load, state stays IDLE.
3. TICK_DIV = 4, start from IDLE with preset 01 -> CE at cycles load+4, +8, +12 and so on, single-cycle each. start -> CE stops. start again -> CE resumes with the phase preserved.
4. Raise done during RUN -> DONE, alarm = 1 for ALARM_SEC×TICK_DIV cycles, then IDLE with I1:I0 unchanged. Repeat and pulse start during DONE -> immediate IDLE.
5. Raise error during PAUSE together with start -> FAULT, not RUN. set while error = 1 -> stays FAULT. Deassert error, then set -> IDLE.
6. Assert reset mid-RUN between prescaler steps -> all outputs 0 asynchronously; after release: state = IDLE, I1 = I0 = 0.
